// File: rtl/ctrl_loop_scheduler.sv
// Fixed-rate control loop scheduler: sequences N_CH ADC conversions, ramps and triggers the PID,
// streams telemetry frames over UART and latches over-voltage faults. Optional ADC watchdog: ADC_TIMEOUT_EN.
module ctrl_loop_scheduler #(
    parameter int CLK_HZ      = 27000000,
    parameter int LOOP_HZ     = 10000,
    parameter int N_CH        = 2,
    parameter int DATA_W      = 8,
    parameter int TELEM_DIV   = 100,
    parameter int RAMP_STEP   = 1,
    parameter int OV_LIMIT    = 240,
    parameter int ADC_TIMEOUT = 4096,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     i_sys_clk,
    input  logic                     i_rst,
    input  logic                     i_enable,
    output logic                     o_adc_start,
    output logic [CH_W-1:0]          o_adc_ch,
    input  logic                     i_adc_done,
    input  logic [DATA_W-1:0]        i_adc_data,
    output logic [N_CH*DATA_W-1:0]   o_ch_data,
    output logic                     o_pid_start,
    output logic [DATA_W-1:0]        o_pid_setpoint,
    output logic [DATA_W-1:0]        o_pid_feedback,
    input  logic                     i_uart_rx_valid,
    input  logic [7:0]               i_uart_rx_data,
    output logic                     o_uart_send,
    output logic [7:0]               o_uart_tx_data,
    input  logic                     i_uart_busy,
    output logic                     o_fault,
    output logic                     o_overrun
);
    localparam int P     = CLK_HZ / LOOP_HZ;
    localparam int CNT_W = $clog2(P);
    localparam int LC_W  = (TELEM_DIV > 1) ? $clog2(TELEM_DIV) : 1;
    localparam int NB    = (DATA_W + 7) / 8;
    localparam int EXT_W = NB * 8;
    localparam int FLEN  = 2 + N_CH * NB;
    localparam int IDX_W = $clog2(FLEN);
    localparam logic [DATA_W-1:0] OV_D   = DATA_W'(OV_LIMIT);
    localparam logic [DATA_W-1:0] STEP_D = DATA_W'(RAMP_STEP);
    localparam logic [31:0]       STEP_U = RAMP_STEP;

    typedef enum logic [1:0] {L_IDLE, L_REQ, L_WAIT, L_PID} lstate_t;
    typedef enum logic [1:0] {T_IDLE, T_SEND, T_WBUSY, T_WDONE} tstate_t;

    lstate_t                      r_lstate;
    tstate_t                      r_tstate;
    logic [CNT_W-1:0]             r_cnt;
    logic [CH_W-1:0]              r_k;
    logic                         r_adc_start;
    logic [CH_W-1:0]              r_adc_ch;
    logic [N_CH-1:0][DATA_W-1:0]  r_ch;
    logic [DATA_W-1:0]            r_fb;
    logic                         r_pid_start;
    logic [LC_W-1:0]              r_loop_cnt;
    logic                         r_overrun;
    logic                         r_fault;
    logic [DATA_W-1:0]            r_target;
    logic [DATA_W-1:0]            r_sp;
    logic [FLEN-1:0][7:0]         r_frame;
    logic [IDX_W-1:0]             r_idx;
    logic                         r_send;
    logic [7:0]                   r_tx;

    logic                         w_tick;
    logic                         w_last;
    logic [DATA_W-1:0]            w_ch0_new;
    logic                         w_fault_set;
    logic                         w_clr;
    logic [DATA_W-1:0]            w_diff;
    logic [DATA_W-1:0]            w_ramp;
    logic                         w_frame_req;
    logic [FLEN-1:0][7:0]         w_frame;
    logic [EXT_W-1:0]             w_ext;

    assign w_tick    = (r_cnt == CNT_W'(P - 1));
    assign w_last    = (r_k == CH_W'(N_CH - 1));
    assign w_ch0_new = (r_k == '0) ? i_adc_data : r_ch[0];
    assign w_clr     = i_uart_rx_valid && (i_uart_rx_data == 8'hFF);

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) r_cnt <= '0;
        else       r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
    end

`ifdef ADC_TIMEOUT_EN
    localparam int TO_W = $clog2(ADC_TIMEOUT + 1);
    logic [TO_W-1:0] r_to;
    logic            w_timeout;
    assign w_timeout = (r_lstate == L_WAIT) && !i_adc_done && (r_to == TO_W'(ADC_TIMEOUT - 1));
`endif

    // pid_start is decided on the final conversion so it lands in the PID cycle itself
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_lstate    <= L_IDLE;
            r_k         <= '0;
            r_adc_start <= 1'b0;
            r_adc_ch    <= '0;
            r_ch        <= '0;
            r_fb        <= '0;
            r_pid_start <= 1'b0;
            r_loop_cnt  <= '0;
`ifdef ADC_TIMEOUT_EN
            r_to        <= '0;
`endif
        end else begin
            r_adc_start <= 1'b0;
            r_pid_start <= 1'b0;
            case (r_lstate)
                L_IDLE: if (w_tick && i_enable) begin
                    r_k      <= '0;
                    r_lstate <= L_REQ;
                end
                L_REQ: begin
                    r_adc_ch    <= r_k;
                    r_adc_start <= 1'b1;
                    r_lstate    <= L_WAIT;
`ifdef ADC_TIMEOUT_EN
                    r_to        <= '0;
`endif
                end
                L_WAIT: begin
                    if (i_adc_done) begin
                        r_ch[r_k] <= i_adc_data;
                        if (r_k == '0) r_fb <= i_adc_data;
                        if (w_last) begin
                            r_lstate    <= L_PID;
                            r_pid_start <= (w_ch0_new < OV_D) && !r_fault;
                        end else begin
                            r_k      <= r_k + CH_W'(1);
                            r_lstate <= L_REQ;
                        end
                    end
`ifdef ADC_TIMEOUT_EN
                    else if (w_timeout) r_lstate <= L_IDLE;
                    else                r_to     <= r_to + TO_W'(1);
`endif
                end
                L_PID: begin
                    r_loop_cnt <= (r_loop_cnt == LC_W'(TELEM_DIV - 1)) ? '0 : r_loop_cnt + LC_W'(1);
                    r_lstate   <= L_IDLE;
                end
                default: r_lstate <= L_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst)                               r_overrun <= 1'b0;
        else if (w_tick && r_lstate != L_IDLE)   r_overrun <= 1'b1;
    end

    always_comb begin
        w_fault_set = (r_lstate == L_PID) && (r_ch[0] >= OV_D);
`ifdef ADC_TIMEOUT_EN
        w_fault_set = w_fault_set | w_timeout;
`endif
    end

    // Saturating step toward target; snaps when within one step
    always_comb begin
        w_diff = '0;
        w_ramp = r_sp;
        if (r_target >= r_sp) begin
            w_diff = r_target - r_sp;
            w_ramp = (32'(w_diff) <= STEP_U) ? r_target : r_sp + STEP_D;
        end else begin
            w_diff = r_sp - r_target;
            w_ramp = (32'(w_diff) <= STEP_U) ? r_target : r_sp - STEP_D;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_fault  <= 1'b0;
            r_target <= '0;
            r_sp     <= '0;
        end else begin
            if (w_fault_set) r_fault <= 1'b1;
            else if (w_clr)  r_fault <= 1'b0;
            if (r_fault) begin
                r_target <= '0;
                r_sp     <= '0;
            end else begin
                if (i_uart_rx_valid && !w_clr) r_target <= DATA_W'(i_uart_rx_data) << (DATA_W - 8);
                if (r_lstate == L_PID)         r_sp     <= w_ramp;
            end
        end
    end

    assign w_frame_req = (r_lstate == L_PID) && (r_loop_cnt == LC_W'(TELEM_DIV - 1));

    always_comb begin
        w_frame    = '0;
        w_ext      = '0;
        w_frame[0] = 8'hA5;
        w_frame[1] = {6'b0, r_overrun, r_fault};
        for (int c = 0; c < N_CH; c++) begin
            w_ext = EXT_W'(r_ch[c]);
            for (int j = 0; j < NB; j++) w_frame[2 + c*NB + j] = w_ext[(NB-1-j)*8 +: 8];
        end
    end

    // Requests arriving outside T_IDLE are dropped rather than queued
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_tstate <= T_IDLE;
            r_frame  <= '0;
            r_idx    <= '0;
            r_send   <= 1'b0;
            r_tx     <= '0;
        end else begin
            r_send <= 1'b0;
            case (r_tstate)
                T_IDLE: if (w_frame_req) begin
                    r_frame  <= w_frame;
                    r_idx    <= '0;
                    r_tstate <= T_SEND;
                end
                T_SEND: if (!i_uart_busy) begin
                    r_send   <= 1'b1;
                    r_tx     <= r_frame[r_idx];
                    r_tstate <= T_WBUSY;
                end
                T_WBUSY: if (i_uart_busy) r_tstate <= T_WDONE;
                T_WDONE: if (!i_uart_busy) begin
                    if (r_idx == IDX_W'(FLEN - 1)) r_tstate <= T_IDLE;
                    else begin
                        r_idx    <= r_idx + IDX_W'(1);
                        r_tstate <= T_SEND;
                    end
                end
                default: r_tstate <= T_IDLE;
            endcase
        end
    end

    assign o_adc_start    = r_adc_start;
    assign o_adc_ch       = r_adc_ch;
    assign o_ch_data      = r_ch;
    assign o_pid_start    = r_pid_start;
    assign o_pid_setpoint = r_sp;
    assign o_pid_feedback = r_fb;
    assign o_uart_send    = r_send;
    assign o_uart_tx_data = r_tx;
    assign o_fault        = r_fault;
    assign o_overrun      = r_overrun;
endmodule

// File: doc/ctrl_loop_scheduler.md
Name: ctrl_loop_scheduler

Overview:
Parametrised successor to the fixed-rate loop timing controller in the buck-boost power controller. Runs a fixed-rate control loop over N_CH ADC channels and triggers the PID on channel 0 each period. Ramps the PID setpoint toward a UART-commanded target, streams framed telemetry over the UART, and latches an over-voltage fault that shuts the loop down. Sits between the ADC driver, PID, and UART in the top level.

Parameters:
CLK_HZ, 27000000, sys_clk frequency in Hz
LOOP_HZ, 10000, control loop rate; period P = CLK_HZ/LOOP_HZ cycles (P >= 16)
N_CH, 2, ADC channels sampled per loop (1..8)
DATA_W, 8, sample and setpoint width (8..16)
TELEM_DIV, 100, loops per telemetry frame (>= 1)
RAMP_STEP, 1, maximum setpoint change per loop, in LSBs of DATA_W
OV_LIMIT, 240, channel-0 over-voltage threshold, DATA_W-wide
ADC_TIMEOUT, 4096, cycles allowed for adc_done (used only with the optional feature)

Ports:
sys_clk  in  1  clock
rst  in  1  synchronous, active-high reset
enable  in  1  loop run enable; ticks are ignored while low
adc_start  out  1  1-cycle conversion request
adc_ch  out  max(1,$clog2(N_CH))  channel select, stable from adc_start until adc_done
adc_done  in  1  1-cycle pulse; adc_data valid on the same cycle
adc_data  in  DATA_W  conversion result
ch_data  out  N_CH*DATA_W  latched samples; channel k occupies bits [k*DATA_W +: DATA_W]
pid_start  out  1  1-cycle PID trigger
pid_setpoint  out  DATA_W  ramped setpoint
pid_feedback  out  DATA_W  channel-0 sample of the current loop
uart_rx_valid  in  1  1-cycle pulse, received byte valid
uart_rx_data  in  8  received byte
uart_send  out  1  1-cycle transmit request
uart_tx_data  out  8  byte to transmit, held from uart_send until uart_busy falls
uart_busy  in  1  transmitter busy
fault  out  1  sticky over-voltage / timeout fault
overrun  out  1  sticky loop overrun flag

Behaviour:
- Reset: every output, the internal tick counter, target, ramp state, loop counter, and both FSMs go to 0 / IDLE.
- Tick: the counter runs 0..P-1 and pulses tick on wrap. It runs regardless of enable.
- Loop FSM states: IDLE, REQ, WAIT, PID.
  - IDLE: on tick with enable=1, clear k to 0 and go to REQ.
  - REQ: drive adc_ch=k, pulse adc_start for one cycle, go to WAIT.
  - WAIT: on adc_done, latch adc_data into ch_data[k]. If k=0, also into pid_feedback. If k<N_CH-1, increment k and go to REQ; otherwise go to PID.
  - PID: update the ramp, then evaluate the fault. If fault=0, pulse pid_start on this cycle. Go to IDLE.
- Tick-to-pid_start latency: N_CH*(2+t_adc)+1 cycles, where t_adc is the adc_start-to-adc_done delay.
- Overrun: a tick arriving while the loop FSM is not IDLE sets overrun (sticky until reset). That tick is dropped; no queueing.
- Ramp (in PID state): if |target - pid_setpoint| <= RAMP_STEP, set pid_setpoint = target; otherwise move it RAMP_STEP toward target. Unsigned arithmetic, no wrap below 0 or above 2^DATA_W-1.
- UART command bytes:
  - 0xFF clears fault and leaves target unchanged.
  - Any other byte b sets target = b << (DATA_W-8).
  - The command is accepted in any state, on the cycle uart_rx_valid is high.
- Fault:
  - Set in PID state when ch_data[0] >= OV_LIMIT.
  - While fault=1: pid_start is suppressed, and pid_setpoint and target are forced to 0 each cycle.
  - If a 0xFF clear and a fault detection occur on the same cycle, the set wins.
- Telemetry: a loop counter increments per completed loop; every TELEM_DIV-th completion requests a frame.
  - Frame layout: 0xA5, status byte {6'b0, overrun, fault}, then for each channel 0..N_CH-1 the value ceil(DATA_W/8) bytes MSB-first, zero-extended.
  - Frame bytes are snapshotted when the request is accepted.
  - A request arriving while a frame is still sending is dropped.
- TX FSM states: TIDLE, SEND, WBUSY, WDONE.
  - SEND: when uart_busy=0, pulse uart_send.
  - WBUSY: wait for uart_busy=1.
  - WDONE: wait for uart_busy=0, then advance to the next byte or return to TIDLE.
- Reset mid-operation: all FSMs return to IDLE / TIDLE on the next edge, and any partial frame is abandoned.
- enable low: a loop already in progress completes; no new loop starts.

Optional Feature:
ADC_TIMEOUT_EN.
- Defined: a counter runs in WAIT. If ADC_TIMEOUT cycles pass without adc_done, set fault, leave ch_data unchanged, and return to IDLE.
- Undefined: WAIT waits indefinitely, and no counter logic is synthesised.

Test Plan:
- Common settings for the bench: CLK_HZ=1000, LOOP_HZ=10 (P=100), N_CH=2, DATA_W=8, TELEM_DIV=2, RAMP_STEP=4, ADC model responds 3 cycles after adc_start.
- ADC model returns ch0=0x40, ch1=0x22 -> adc_start on ch0 then ch1 each period; ch_data=0x2240; pid_feedback=0x40; pid_start fires 11 cycles after tick, once per 100 cycles.
- UART rx 0x10 with setpoint at 0 -> pid_setpoint reads 4, 8, 12, 16 on successive loops, then holds at 16; rx 0x0E -> 14 on the next loop.
- Completion of the 2nd loop -> tx bytes A5, 00, 40, 22 in order; each uart_send issued only with uart_busy=0, one send per busy cycle.
- ch0=0xF0 -> fault=1; pid_start absent; pid_setpoint=0; rx 0x30 is ignored; rx 0xFF with ch0=0x40 -> fault=0, and ramp restarts from 0 on the next 0x30.
- ADC model delays 150 cycles -> overrun=1 and a tick is dropped. With ADC_TIMEOUT_EN and ADC_TIMEOUT=50 -> fault=1 at 50 cycles, FSM returns to IDLE.
- Assert rst during WAIT and during a frame -> all outputs 0 on the next edge; no further uart_send until the next frame.
